// File: rtl/alu_pkg.sv
// Shared widths, opcode constants and issue-FSM states for the 4-bit ALU datapath.
package alu_pkg;

    localparam int ALU_W = 4;
    localparam int OP_W  = 3;
    localparam int CMD_W = OP_W + 2 * ALU_W;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage: {op,a,b} entries, power-of-2 depth.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = CMD_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_4b.sv
// ALU issue stage: queues commands, launches one at a time into the ALU, waits
// ALU_LAT edges, then returns the registered result over a valid/ready response.
module alu_issue_4b
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 2,
    parameter int ALU_LAT   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [ALU_W-1:0] alu_f_reg,
    input  logic             alu_cout_reg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam int FCW   = $clog2(CMD_DEPTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ALU_W-1:0] alu_a_q, alu_a_d;
    logic [ALU_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ALU_W-1:0] rsp_f_q, rsp_f_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    logic [CMD_W-1:0] fifo_dout;

    // Ready depends only on registered occupancy, so a full FIFO refuses a push
    // even on an edge where the FSM pops.
    assign cmd_ready = ~fifo_full;
    assign fifo_push = cmd_valid & ~fifo_full;

    alu_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     ({cmd_op, cmd_a, cmd_b}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_f_d     = rsp_f_q;
        rsp_cout_d  = rsp_cout_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                      = 1'b1;
                    {alu_op_d, alu_a_d, alu_b_d}  = fifo_dout;
                    cnt_d                         = CNT_W'(ALU_LAT);
                    state_d                       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_f_d     = alu_f_reg;
                    rsp_cout_d  = alu_cout_reg;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_f_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_f_q     <= rsp_f_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
